// File: rtl/sr04_sched_pkg.sv
// Shared definitions for the HC-SR04 measurement sequencer: FSM state codes
// and result error codes.
package sr04_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEAS      = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_NOECHO = 2'd1;
  localparam logic [1:0] ERR_OVR    = 2'd2;

endpackage

// File: rtl/sr04_sched_sync_edge.sv
// Two-flop synchronizer for an asynchronous level input, followed by a
// delay flop so that single-cycle rise/fall pulses can be derived from the
// synchronized level. Usable for the echo pin as well as for key inputs.
module sr04_sched_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  // Metastability chain plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      dly  <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~dly;
  assign fall  = ~sync & dly;

endmodule

// File: rtl/sr04_sched.sv
// HC-SR04 measurement sequencer: trigger pulse, echo timing in clk_1m cycles,
// minimum trigger-to-trigger period and one result per measurement cycle.
//
// Result interface: res_vld is a one-cycle strobe with no back-pressure; the
// consumer samples res_echo/res_err on the cycle res_vld is high, and both
// hold their value until the next strobe.
module sr04_sched
  import sr04_sched_pkg::*;
#(
  parameter int TRIG_US      = 10,
  parameter int ECHO_WAIT_US = 1000,
  parameter int ECHO_MAX_US  = 38000,
  parameter int PERIOD_US    = 60000,
  parameter int CW           = 16
) (
  input  logic          clk_1m,
  input  logic          rst_n,
  input  logic          cfg_auto,
  input  logic          start,
  input  logic          s1_echo,
  output logic          s1_trig,
  output logic          busy,
  output logic          res_vld,
  output logic [CW-1:0] res_echo,
  output logic [1:0]    res_err,
  output logic [2:0]    dbg_state
);

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_US - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(ECHO_WAIT_US - 1);
  localparam logic [CW-1:0] ECHO_MAX  = CW'(ECHO_MAX_US);
  localparam logic [CW-1:0] PERIOD    = CW'(PERIOD_US);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;     // trigger width, then echo-rise wait
  logic [CW-1:0] ecnt, ecnt_n;   // echo width
  logic [CW-1:0] pcnt;           // cycles since trigger rise, saturating
  logic          pending;
  logic          trig_entry;
  logic          ld;
  logic [CW-1:0] ld_echo;
  logic [1:0]    ld_err;
  logic          echo_s, echo_rise, echo_fall;

  sr04_sched_sync_edge u_echo_sync (
    .clk   (clk_1m),
    .rst_n (rst_n),
    .din   (s1_echo),
    .level (echo_s),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  // Next-state, counter updates and result load decisions.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ecnt_n     = ecnt;
    trig_entry = 1'b0;
    ld         = 1'b0;
    ld_echo    = '0;
    ld_err     = ERR_OK;
    case (state)
      ST_IDLE: begin
        if (start || pending || cfg_auto) begin
          state_n    = ST_TRIG;
          cnt_n      = '0;
          trig_entry = 1'b1;
        end
      end
      ST_TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_n = ST_WAIT_RISE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        // A level already high on entry shows no rise and times out.
        if (echo_rise) begin
          state_n = ST_MEAS;
          ecnt_n  = CW'(1);
        end else if (cnt == WAIT_LAST) begin
          state_n = ST_HOLDOFF;
          ld      = 1'b1;
          ld_err  = ERR_NOECHO;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_MEAS: begin
        if (echo_fall) begin
          state_n = ST_HOLDOFF;
          ld      = 1'b1;
          ld_echo = ecnt;
        end else if (ecnt == ECHO_MAX) begin
          state_n = ST_HOLDOFF;
          ld      = 1'b1;
          ld_echo = ECHO_MAX;
          ld_err  = ERR_OVR;
        end else begin
          ecnt_n = ecnt + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        // An overranged echo must finish before the sensor is re-triggered.
        if (pcnt == PERIOD && !echo_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and measurement counters.
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ecnt  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ecnt  <= ecnt_n;
    end
  end

  // Period counter: the trigger-rise cycle counts as the first elapsed cycle,
  // so leaving HOLDOFF at PERIOD and passing through IDLE gives a rise-to-rise
  // spacing of PERIOD_US+1 cycles.
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (trig_entry) begin
      pcnt <= CW'(1);
    end else if (pcnt != PERIOD) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Single pending bit: starts arriving while busy merge into one request.
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (trig_entry) begin
      pending <= 1'b0;
    end else if (start && state != ST_IDLE) begin
      pending <= 1'b1;
    end
  end

  // Registered trigger and result outputs.
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      s1_trig  <= 1'b0;
      res_vld  <= 1'b0;
      res_echo <= '0;
      res_err  <= ERR_OK;
    end else begin
      s1_trig <= (state_n == ST_TRIG);
      res_vld <= ld;
      if (ld) begin
        res_echo <= ld_echo;
        res_err  <= ld_err;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_sr04_sched.sv
// Self-checking bench for sr04_sched with scaled-down timing parameters.
// Stimulus issues measurements and pushes expected results; an independent
// monitor pops and compares on every res_vld.
module tb_sr04_sched;

  localparam int TRIG = 10;
  localparam int WAIT = 400;
  localparam int EMAX = 1500;
  localparam int PER  = 3000;
  localparam int CW   = 16;

  logic          clk_1m = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_auto = 1'b0;
  logic          start = 1'b0;
  logic          s1_echo = 1'b0;
  logic          s1_trig;
  logic          busy;
  logic          res_vld;
  logic [CW-1:0] res_echo;
  logic [1:0]    res_err;
  logic [2:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int push_cnt = 0;
  int last_echo_fall = 0;
  logic [17:0] exp_q[$];
  int rise_q[$];

  sr04_sched #(
    .TRIG_US(TRIG), .ECHO_WAIT_US(WAIT), .ECHO_MAX_US(EMAX),
    .PERIOD_US(PER), .CW(CW)
  ) dut (
    .clk_1m(clk_1m), .rst_n(rst_n), .cfg_auto(cfg_auto), .start(start),
    .s1_echo(s1_echo), .s1_trig(s1_trig), .busy(busy), .res_vld(res_vld),
    .res_echo(res_echo), .res_err(res_err), .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk_1m = ~clk_1m;
  always @(posedge clk_1m) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, got, lo, hi, cyc);
    end
  endtask

  // Reference: a reply counts only if it starts inside the listening window;
  // replies longer than the maximum are clipped and flagged as overrange.
  function automatic logic [17:0] ref_result(input bit noecho, input int d, input int w);
    if (noecho || d >= WAIT) return {2'd1, 16'd0};
    if (w > EMAX) return {2'd2, 16'(EMAX)};
    return {2'd0, 16'(w)};
  endfunction

  // Scoreboard monitor.
  logic [17:0] mon_e;
  int mon_tol;
  always @(negedge clk_1m) begin
    if (rst_n && res_vld) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_res_vld: echo=%0d err=%0d, expected no result", res_echo, res_err);
      end else begin
        mon_e = exp_q.pop_front();
        mon_tol = (mon_e[17:16] == 2'd0) ? 1 : 0;
        check("res_err", int'(res_err), int'(mon_e[17:16]), int'(mon_e[17:16]));
        check("res_echo", int'(res_echo), int'(mon_e[15:0]) - mon_tol, int'(mon_e[15:0]) + mon_tol);
      end
    end
  end

  // Trigger monitor: pulse width and rise-to-rise spacing.
  logic trig_prev = 1'b0;
  int trig_w = 0;
  int last_rise = -1;
  always @(negedge clk_1m) begin
    if (!rst_n) begin
      trig_prev = 1'b0;
      trig_w = 0;
      last_rise = -1;
    end else begin
      if (s1_trig && !trig_prev) begin
        if (last_rise >= 0) check("trig_spacing", cyc - last_rise, PER + 1, 1 << 30);
        last_rise = cyc;
        rise_q.push_back(cyc);
        trig_w = 1;
      end else if (s1_trig) begin
        trig_w++;
      end else if (trig_prev) begin
        check("trig_width", trig_w, TRIG, TRIG);
      end
      trig_prev = s1_trig;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_1m);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk_1m);
    start = 1'b0;
  endtask

  task automatic wait_trig_fall(output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk_1m);
      if (s1_trig) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("trig_fall_timeout", 0, 1, 1);
  endtask

  // Echo responder: waits for the trigger to end, then answers after d cycles
  // with a pulse w cycles wide (or stays silent).
  task automatic respond(input bit noecho, input int d, input int w, input bit push);
    bit ok;
    wait_trig_fall(ok);
    if (!ok) return;
    if (push) begin
      exp_q.push_back(ref_result(noecho, d, w));
      push_cnt++;
    end
    if (noecho) return;
    tick(d);
    s1_echo = 1'b1;
    tick(w);
    s1_echo = 1'b0;
    last_echo_fall = cyc;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk_1m);
      if (!busy) break;
    end
    check("idle_timeout", int'(busy), 0, 0);
  endtask

  task automatic wait_echo_high;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_1m);
      if (s1_echo) break;
    end
  endtask

  initial begin
    bit ok;
    int f, t0, n0, kind, d, w;

    // Reset state.
    tick(3);
    check("rst_trig", int'(s1_trig), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_vld", int'(res_vld), 0, 0);
    check("rst_echo", int'(res_echo), 0, 0);
    check("rst_err", int'(res_err), 0, 0);
    rst_n = 1'b1;
    tick(3);
    check("idle_busy", int'(busy), 0, 0);

    // Single shot, 580-cycle echo; busy drops PER cycles after trigger rise.
    pulse_start();
    respond(1'b0, 200, 580, 1'b1);
    t0 = rise_q[$];
    while (cyc < t0 + PER - 1) @(negedge clk_1m);
    check("busy_before_period", int'(busy), 1, 1);
    @(negedge clk_1m);
    check("busy_after_period", int'(busy), 0, 0);

    // No echo: timeout result WAIT cycles after trigger end.
    pulse_start();
    wait_trig_fall(ok);
    f = cyc;
    exp_q.push_back(ref_result(1'b1, 0, 0));
    push_cnt++;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_1m);
      if (res_vld) break;
    end
    check("noecho_latency", cyc - f, WAIT - 1, WAIT + 1);
    wait_idle();

    // Overrange with an echo outlasting the period; a start while busy queues
    // one more cycle that must wait for the echo to end.
    pulse_start();
    fork
      respond(1'b0, 200, 3200, 1'b1);
      begin
        tick(500);
        pulse_start();
      end
    join
    respond(1'b1, 0, 0, 1'b1);
    check("retrig_after_echo_fall", rise_q[$] - last_echo_fall, 3, 1 << 30);
    wait_idle();

    // Free-running mode with randomized echoes; auto dropped in the last cycle.
    n0 = rise_q.size();
    cfg_auto = 1'b1;
    for (int i = 0; i < 5; i++) begin
      kind = $urandom_range(0, 3);
      d = $urandom_range(20, 300);
      w = (kind == 1) ? $urandom_range(1600, 2400) : $urandom_range(1, 1400);
      if (i == 4) begin
        for (int k = 0; k < 8000; k++) begin
          @(negedge clk_1m);
          if (s1_trig) break;
        end
        cfg_auto = 1'b0;
      end
      respond(kind == 0, d, w, 1'b1);
    end
    wait_idle();
    tick(PER + 200);
    check("auto_rise_count", rise_q.size() - n0, 5, 5);
    for (int k = 1; k < 5; k++) begin
      if (n0 + k < rise_q.size())
        check("auto_spacing", rise_q[n0 + k] - rise_q[n0 + k - 1], PER + 1, PER + 1);
    end

    // Three starts during MEAS merge into one extra measurement.
    n0 = rise_q.size();
    pulse_start();
    fork
      respond(1'b0, 100, 800, 1'b1);
      begin
        wait_echo_high();
        tick(50);
        pulse_start();
        tick(100);
        pulse_start();
        tick(100);
        pulse_start();
      end
    join
    respond(1'b0, 150, 300, 1'b1);
    wait_idle();
    tick(PER + 200);
    check("pending_rise_count", rise_q.size() - n0, 2, 2);

    // Reset during TRIG.
    pulse_start();
    tick(3);
    rst_n = 1'b0;
    #1;
    check("rst_trig_during_trig", int'(s1_trig), 0, 0);
    check("rst_busy_during_trig", int'(busy), 0, 0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    pulse_start();
    respond(1'b0, 120, 450, 1'b1);
    wait_idle();

    // Reset during MEAS.
    pulse_start();
    wait_trig_fall(ok);
    tick(100);
    s1_echo = 1'b1;
    tick(200);
    rst_n = 1'b0;
    #1;
    check("rst_trig_during_meas", int'(s1_trig), 0, 0);
    check("rst_vld_during_meas", int'(res_vld), 0, 0);
    check("rst_busy_during_meas", int'(busy), 0, 0);
    s1_echo = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    pulse_start();
    respond(1'b0, 60, 1234, 1'b1);
    wait_idle();

    tick(10);
    check("exp_q_drained", exp_q.size(), 0, 0);
    check("result_count", vld_cnt, push_cnt, push_cnt);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
